// File: rtl/alu_mul_seq_if.sv
// Bundle of the multiplier request/result handshake and the shared-ALU bus.
// The slave modport is the multiplier controller. The master modport is the
// execute stage, which issues requests and supplies the ALU result.
interface alu_mul_seq_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  start;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] product;
   logic                  alu_req;
   logic [DATA_WIDTH-1:0] alu_op1;
   logic [DATA_WIDTH-1:0] alu_op2;
   logic [2:0]            alu_ctrl;
   logic [DATA_WIDTH-1:0] alu_out;

   modport slave (
      input  start, mcand, mplier, alu_out,
      output busy, done, product, alu_req, alu_op1, alu_op2, alu_ctrl
   );

   modport master (
      output start, mcand, mplier, alu_out,
      input  busy, done, product, alu_req, alu_op1, alu_op2, alu_ctrl
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows the shared integer ALU.
// Each set multiplier bit costs one ADD cycle (acc += mcand). Every bit
// position costs one SHL cycle (mcand <<= 1). product is the low DATA_WIDTH
// bits of mcand*mplier.
// Optional build macro ALU_MUL_SEQ_EARLY_EXIT_EN: stop shifting once no set
// multiplier bits remain, and finish immediately for a zero multiplier.
module alu_mul_seq #(
   parameter int DATA_WIDTH = 32
) (
   input logic           clk,
   input logic           rst_n,
   alu_mul_seq_if.slave  bus
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [2:0] CTRL_ADD = 3'b000;
   localparam logic [2:0] CTRL_SHL = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADD,
      ST_SHL,
      ST_DONE
   } state_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] acc_reg;
   logic [DATA_WIDTH-1:0] mcand_reg;
   logic [DATA_WIDTH-1:0] mplier_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic                  shl_last;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
   // Finish once the remaining multiplier bits are all zero. The counter term
   // can never fire first, because by then every bit has been shifted out.
   assign shl_last = ((mplier_reg >> 1) == '0) || (cnt_reg == CNT_W'(DATA_WIDTH - 1));
`else
   // Always walk every bit position of the multiplier.
   assign shl_last = (cnt_reg == CNT_W'(DATA_WIDTH - 1));
`endif

   assign bus.product = acc_reg;

   // State register. Reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode plus ALU steering and status outputs.
   always_comb begin
      state_next   = state_reg;
      bus.busy     = 1'b0;
      bus.alu_req  = 1'b0;
      bus.done     = 1'b0;
      bus.alu_op1  = '0;
      bus.alu_op2  = '0;
      bus.alu_ctrl = CTRL_ADD;
      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
               if (bus.mplier == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = bus.mplier[0] ? ST_ADD : ST_SHL;
               end
`else
               state_next = bus.mplier[0] ? ST_ADD : ST_SHL;
`endif
            end
         end
         ST_ADD: begin
            bus.busy    = 1'b1;
            bus.alu_req = 1'b1;
            bus.alu_op1 = acc_reg;
            bus.alu_op2 = mcand_reg;
            state_next  = ST_SHL;
         end
         ST_SHL: begin
            bus.busy     = 1'b1;
            bus.alu_req  = 1'b1;
            bus.alu_op1  = mcand_reg;
            bus.alu_op2  = DATA_WIDTH'(1);
            bus.alu_ctrl = CTRL_SHL;
            if (shl_last) begin
               state_next = ST_DONE;
            end else begin
               // Bit 1 becomes the next bit 0 after this cycle's shift.
               state_next = mplier_reg[1] ? ST_ADD : ST_SHL;
            end
         end
         ST_DONE: begin
            bus.done   = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand capture and accumulation of the ALU results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  acc_reg    <= '0;
                  mcand_reg  <= bus.mcand;
                  mplier_reg <= bus.mplier;
                  cnt_reg    <= '0;
               end
            end
            ST_ADD: begin
               acc_reg <= bus.alu_out;
            end
            ST_SHL: begin
               mcand_reg  <= bus.alu_out;
               mplier_reg <= mplier_reg >> 1;
               if (!shl_last) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq. A combinational ALU model sits on
// the shared bus. Expected products and cycle counts come from plain
// arithmetic on the operands. Honours ALU_MUL_SEQ_EARLY_EXIT_EN if defined.
module tb_alu_mul_seq;
   localparam int DW = 32;

   logic clk;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;

   alu_mul_seq_if #(.DATA_WIDTH(DW)) bus ();

   alu_mul_seq #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Shared integer ALU: add and shift-left are the only codes used here.
   assign bus.alu_out = (bus.alu_ctrl == 3'b000) ? bus.alu_op1 + bus.alu_op2 :
                        (bus.alu_ctrl == 3'b100) ? bus.alu_op1 << bus.alu_op2 : '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [DW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] p;
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return p[DW-1:0];
   endfunction

   function automatic int ref_adds(input logic [DW-1:0] b);
      return $countones(b);
   endfunction

   function automatic int ref_shls(input logic [DW-1:0] b);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
      int top;
      top = 0;
      for (int i = 0; i < DW; i++) if (b[i]) top = i + 1;
      return top;
`else
      return (b == b) ? DW : DW;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Waits for done, tallying the busy cycles and the ALU codes seen.
   // inject_at >= 0 pulses a spurious start for one cycle at that busy count.
   task automatic wait_done(input int inject_at, output int nbusy, output int nadd,
                            output int nshl, output bit req_ok, output bit got);
      nbusy = 0; nadd = 0; nshl = 0; req_ok = 1'b1; got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (inject_at >= 0) begin
            if (nbusy == inject_at) begin
               bus.start  = 1'b1;
               bus.mcand  = 32'd5;
               bus.mplier = 32'd1;
            end else begin
               bus.start = 1'b0;
            end
         end
         if (bus.alu_req !== bus.busy) req_ok = 1'b0;
         if (bus.done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) begin
            nbusy++;
            if (bus.alu_ctrl == 3'b000) nadd++;
            else if (bus.alu_ctrl == 3'b100) nshl++;
         end
      end
   endtask

   // Full single operation from an idle DUT, ending one cycle after done.
   task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp, input int inject_at);
      int nbusy, nadd, nshl;
      bit req_ok, got;
      logic [DW-1:0] p;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.mcand  = a;
      bus.mplier = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.mcand  = ~a;
      bus.mplier = ~b;
      wait_done(inject_at, nbusy, nadd, nshl, req_ok, got);
      p = bus.product;
      check({tag, " done_seen"}, 64'(got), 64'(1));
      check({tag, " product"}, 64'(p), 64'(exp));
      check({tag, " latency"}, 64'(nbusy), 64'(ref_adds(b) + ref_shls(b)));
      check({tag, " add_cycles"}, 64'(nadd), 64'(ref_adds(b)));
      check({tag, " shl_cycles"}, 64'(nshl), 64'(ref_shls(b)));
      check({tag, " alu_req"}, 64'(req_ok), 64'(1));
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(bus.done), 64'(0));
      check({tag, " product_hold"}, 64'(bus.product), 64'(exp));
      $display("op %s: %h * %h -> %h busy %0d (add %0d shl %0d)", tag, a, b, p, nbusy, nadd, nshl);
   endtask

   initial begin
      int nbusy, nadd, nshl;
      bit req_ok, got;
      logic [DW-1:0] a, b;

      vecs[0] = '{a: 32'd3,         b: 32'd5,         exp: 32'd15};
      vecs[1] = '{a: 32'hFFFFFFFF,  b: 32'd2,         exp: 32'hFFFFFFFE};
      vecs[2] = '{a: 32'h80000000,  b: 32'hFFFFFFFF,  exp: 32'h80000000};
      vecs[3] = '{a: 32'h1234,      b: 32'd0,         exp: 32'd0};
      vecs[4] = '{a: 32'hA,         b: 32'hB,         exp: 32'h6E};
      vecs[5] = '{a: 32'd0,         b: 32'hFFFFFFFF,  exp: 32'd0};
      vecs[6] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  exp: 32'd1};
      vecs[7] = '{a: 32'd1,         b: 32'h80000000,  exp: 32'h80000000};

      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.mcand = '0;
      bus.mplier = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'(0));
      check("reset done", 64'(bus.done), 64'(0));
      check("reset product", 64'(bus.product), 64'(0));
      check("reset alu_req", 64'(bus.alu_req), 64'(0));
      check("reset alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
      rst_n = 1'b1;

      // Reset in the middle of an operation discards it.
      @(negedge clk);
      bus.start = 1'b1; bus.mcand = 32'd7; bus.mplier = 32'd9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      check("midop busy_before", 64'(bus.busy), 64'(1));
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst busy", 64'(bus.busy), 64'(0));
      check("midrst done", 64'(bus.done), 64'(0));
      check("midrst product", 64'(bus.product), 64'(0));
      check("midrst alu_req", 64'(bus.alu_req), 64'(0));
      check("midrst alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
      rst_n = 1'b1;
      run_op("after_rst", 32'd2, 32'd3, 32'd6, -1);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, -1);
      end

      // The worst-case operand pair needs 64 busy cycles in either build.
      check("worst latency model", 64'(ref_adds(32'hFFFFFFFF) + ref_shls(32'hFFFFFFFF)), 64'(64));

      // Spurious start while busy must not disturb the running product.
      run_op("ignore_start", 32'hA, 32'hB, 32'h6E, 3);

      // Back-to-back: start held high, next accept one cycle after done.
      @(negedge clk);
      bus.start = 1'b1; bus.mcand = 32'd4; bus.mplier = 32'd6;
      @(posedge clk);
      wait_done(-1, nbusy, nadd, nshl, req_ok, got);
      check("b2b first done", 64'(got), 64'(1));
      check("b2b first product", 64'(bus.product), 64'(24));
      bus.mcand = 32'd7; bus.mplier = 32'd3;
      @(negedge clk);
      check("b2b idle busy", 64'(bus.busy), 64'(0));
      check("b2b idle done", 64'(bus.done), 64'(0));
      check("b2b idle product", 64'(bus.product), 64'(24));
      @(negedge clk);
      check("b2b accepted busy", 64'(bus.busy), 64'(1));
      check("b2b cleared product", 64'(bus.product), 64'(0));
      bus.start = 1'b0;
      wait_done(-1, nbusy, nadd, nshl, req_ok, got);
      check("b2b second done", 64'(got), 64'(1));
      check("b2b second product", 64'(bus.product), 64'(21));
      check("b2b second latency", 64'(nbusy + 1), 64'(ref_adds(32'd3) + ref_shls(32'd3)));
      $display("op b2b: 4*6 then 7*3 -> %h", bus.product);

      // Hold: result and idle ALU outputs are stable.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold product", 64'(bus.product), 64'(21));
         check("hold busy", 64'(bus.busy), 64'(0));
         check("hold op1", 64'(bus.alu_op1), 64'(0));
         check("hold op2", 64'(bus.alu_op2), 64'(0));
      end

      // Random operands with a spread of multiplier densities.
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         case (i % 4)
            0: ;
            1: b = b & 32'h000000FF;
            2: b = b >> $urandom_range(0, 31);
            default: b = 32'd1 << $urandom_range(0, 31);
         endcase
         run_op($sformatf("rnd%0d", i), a, b, ref_prod(a, b), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiplier controller that sequences the shared integer ALU instead of instantiating a hardware multiplier.
- On `start`, it takes ownership of the ALU via `alu_req`, drives operands and ALU control codes, and captures `alu_out` into internal registers.
- Sits beside the execute stage. The pipeline muxes the ALU inputs to this block while `alu_req=1`, and stalls until `done`.

Parameters:
- DATA_WIDTH, 32, width of operands, ALU bus and product. Must be ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mcand  in  DATA_WIDTH  multiplicand; captured on accepted start
- mplier  in  DATA_WIDTH  multiplier; captured on accepted start
- busy  out  1  high in ADD and SHL states
- done  out  1  one-cycle pulse; `product` valid
- product  out  DATA_WIDTH  low DATA_WIDTH bits of mcand*mplier
- alu_req  out  1  ALU ownership request; equal to `busy`
- alu_op1  out  DATA_WIDTH  ALU operand 1
- alu_op2  out  DATA_WIDTH  ALU operand 2
- alu_ctrl  out  3  ALU control code (000 add, 100 shift left)
- alu_out  in  DATA_WIDTH  ALU result; combinational from `alu_op*`/`alu_ctrl` in the same cycle

Behaviour:
- Reset is synchronous: `rst_n=0` at a clock edge forces the following.
  - State → IDLE.
  - `acc`, `mcand_r`, `mplier_r`, `cnt`, `product` → 0.
  - `busy`, `done`, `alu_req` → 0.
- Reset overrides everything, including mid-operation; the in-flight result is discarded.
- Internal registers: `acc`, `mcand_r`, `mplier_r` (DATA_WIDTH bits each); `cnt` ($clog2(DATA_WIDTH) bits).
- State IDLE
  - Outputs: `alu_op1=0`, `alu_op2=0`, `alu_ctrl=000`.
  - On `start`: load `mcand_r=mcand`, `mplier_r=mplier`, `acc=0`, `cnt=0`.
  - Next state: ADD if `mplier[0]`, else SHL.
- State ADD
  - Outputs: `alu_op1=acc`, `alu_op2=mcand_r`, `alu_ctrl=000`.
  - Edge: `acc<=alu_out`; next state SHL.
- State SHL
  - Outputs: `alu_op1=mcand_r`, `alu_op2=1`, `alu_ctrl=100`.
  - Edge: `mcand_r<=alu_out`, `mplier_r<=mplier_r>>1`.
  - If `cnt==DATA_WIDTH-1`: next state DONE.
  - Otherwise: `cnt++`; next state ADD if `mplier_r[1]`, else SHL.
- State DONE
  - `done=1` for this one cycle; `product` reflects `acc`.
  - ALU outputs as in IDLE.
  - Next state IDLE.
- `product` is continuously driven from `acc`. It holds the result from DONE until the next accepted start, where it becomes 0 because `acc` is cleared.
- Latency, start-accept edge to `done` high: DATA_WIDTH + popcount(mplier) cycles. `done` is visible in the cycle after the last SHL.
- Arithmetic is modulo 2^DATA_WIDTH. High product bits are dropped, with no overflow flag. Operands are treated as unsigned; the low DATA_WIDTH bits are identical for signed operands.
- `start` is ignored in ADD, SHL and DONE; there is no queuing.
- `mcand`/`mplier` changes after acceptance have no effect.
- `start` held high continuously: a new operation is accepted in every IDLE cycle, i.e. once per DONE→IDLE return.

Optional Feature:
- Macro: ALU_MUL_SEQ_EARLY_EXIT_EN.
- Defined:
  - IDLE with `start` and `mplier==0` goes directly to DONE, with `product=0`.
  - SHL goes to DONE when `(mplier_r>>1)==0`, regardless of `cnt`.
  - Latency becomes (index of highest set bit of mplier + 1) + popcount(mplier), with a minimum of 0 busy cycles.
- Undefined:
  - Fixed DATA_WIDTH SHL iterations, as specified above.
  - The `product` value is identical in both builds.

Test Plan:
- Reset mid-op: start 7*9, assert `rst_n=0` after 5 cycles → next cycle `busy=0`, `done=0`, `product=0`, `alu_req=0`, `alu_ctrl=000`. A following start 2*3 then gives 6.
- Basic: `mcand=3`, `mplier=5` → `done` 34 cycles after accept, `product=15`. Without the macro: 2 ADD cycles (`alu_ctrl=000`) and 32 SHL cycles (`alu_ctrl=100`). With the macro: 5 busy cycles.
- Overflow: `mcand=0xFFFFFFFF`, `mplier=2` → `product=0xFFFFFFFE`. Also `mcand=0x80000000`, `mplier=0xFFFFFFFF` → `product=0x80000000`, with `done` 64 cycles after accept.
- Zero multiplier: `mplier=0`, `mcand=0x1234` → `product=0`. `done` after 32 cycles without the macro, or in the cycle after accept with the macro.
- Handshake: pulse `start` again during busy with `mplier=1` → ignored; the first result (`0xA*0xB=0x6E`) is unchanged. Back-to-back start held high gives a second accept exactly one cycle after `done`.
- Hold: after `done`, idle 10 cycles → `product` stable, `busy=0`, `alu_op1=0`, `alu_op2=0`.
